// File: rtl/uart_tx_feeder.sv
// Byte FIFO that feeds a UART transmitter through its tx_dv/tx_byte/tx_done handshake.
// A new start is only issued once the transmitter's two-cycle done pulse has fully ended.
module uart_tx_feeder #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_valid,
  input  logic [7:0]      wr_data,
  output logic            wr_ready,
  input  logic            clr_overflow,
  output logic            tx_dv,
  output logic [7:0]      tx_byte,
  input  logic            tx_done,
  output logic [ADDR_W:0] fifo_count,
  output logic            busy,
  output logic            overflow
);

  localparam logic [ADDR_W:0] CountFull = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWaitDone,
    StGap
  } state_e;

  state_e            state_q;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic              tx_dv_q;
  logic [7:0]        tx_byte_q;
  logic              overflow_q;
  logic              push;
  logic              pop;

  // No pass-through: a full FIFO refuses writes even on a pop cycle.
  assign wr_ready   = (count_q != CountFull);
  assign push       = wr_valid && wr_ready;
  assign pop        = (state_q == StIdle) && (count_q != '0);
  assign fifo_count = count_q;
  assign busy       = (state_q != StIdle) || (count_q != '0);
  assign overflow   = overflow_q;
  assign tx_dv      = tx_dv_q;
  assign tx_byte    = tx_byte_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (ADDR_W + 1)'(1);
        2'b01:   count_q <= count_q - (ADDR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
      // A rejected write wins over a simultaneous clear.
      if (wr_valid && !wr_ready) begin
        overflow_q <= 1'b1;
      end else if (clr_overflow) begin
        overflow_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
    end else begin
      case (state_q)
        StIdle: begin
          tx_dv_q <= 1'b0;
          if (pop) begin
            tx_byte_q <= mem[rd_ptr_q];
            tx_dv_q   <= 1'b1;
            state_q   <= StSend;
          end
        end
        StSend: begin
          tx_dv_q <= 1'b0;
          state_q <= StWaitDone;
        end
        StWaitDone: begin
          tx_dv_q <= 1'b0;
          if (tx_done) begin
            state_q <= StGap;
          end
        end
        StGap: begin
          tx_dv_q <= 1'b0;
          if (!tx_done) begin
            state_q <= StIdle;
          end
        end
        default: begin
          tx_dv_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a simple transmitter model that answers each
// tx_dv with a two-cycle tx_done pulse after a fixed byte time.
module tb_uart_tx_feeder;

  localparam int unsigned DEPTH    = 16;
  localparam int unsigned ADDR_W   = 4;
  localparam int          ByteTime = 20;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            wr_valid = 1'b0;
  logic [7:0]      wr_data = 8'h00;
  logic            wr_ready;
  logic            clr_overflow = 1'b0;
  logic            tx_dv;
  logic [7:0]      tx_byte;
  logic            tx_done = 1'b0;
  logic [ADDR_W:0] fifo_count;
  logic            busy;
  logic            overflow;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_feeder #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .clr_overflow (clr_overflow),
    .tx_dv        (tx_dv),
    .tx_byte      (tx_byte),
    .tx_done      (tx_done),
    .fifo_count   (fifo_count),
    .busy         (busy),
    .overflow     (overflow)
  );

  // Transmitter model, evaluated on the falling edge; stall freezes the byte timer.
  logic       stall = 1'b0;
  int         m_cnt = 0;
  int         m_done = 0;
  int         dv_pulses = 0;
  int         dv_double = 0;
  int         dv_during_done = 0;
  logic       prev_dv = 1'b0;
  logic [7:0] log_q [$];

  always @(negedge clk) begin
    if (reset) begin
      m_cnt   = 0;
      m_done  = 0;
      tx_done = 1'b0;
      prev_dv = 1'b0;
    end else begin
      if (tx_dv === 1'b1) begin
        dv_pulses++;
        log_q.push_back(tx_byte);
        if (prev_dv) dv_double++;
        if (tx_done) dv_during_done++;
        m_cnt = ByteTime;
      end else if (m_cnt > 0 && !stall) begin
        m_cnt--;
        if (m_cnt == 0) m_done = 2;
      end
      prev_dv = (tx_dv === 1'b1);
      tx_done = (m_done > 0);
      if (m_done > 0) m_done--;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i = 0;
    while (busy !== 1'b0 && i < budget) begin
      tick(1);
      i++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    int peak;
    int order_err;

    // Reset held with a write pending: nothing may enqueue.
    reset    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'h77;
    tick(3);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_tx_dv", 32'(tx_dv), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'h00);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset    = 1'b0;
    wr_valid = 1'b0;
    tick(3);
    check("rst_no_enqueue", 32'(fifo_count), 32'd0);
    check("rst_no_dv", 32'(dv_pulses), 32'd0);

    // Single byte: count 1 after E, tx_dv high E+1..E+2.
    wr_valid = 1'b1;
    wr_data  = 8'hA5;
    tick(1);
    wr_valid = 1'b0;
    check("single_count_e", 32'(fifo_count), 32'd1);
    check("single_dv_e", 32'(tx_dv), 32'd0);
    tick(1);
    check("single_dv_e1", 32'(tx_dv), 32'd1);
    check("single_byte", 32'(tx_byte), 32'hA5);
    check("single_count_pop", 32'(fifo_count), 32'd0);
    check("single_busy", 32'(busy), 32'd1);
    tick(1);
    check("single_dv_e2", 32'(tx_dv), 32'd0);
    check("single_byte_hold", 32'(tx_byte), 32'hA5);
    wait_idle("single_idle", 200);
    check("single_done_low", 32'(tx_done), 32'd0);
    check("single_pulses", 32'(dv_pulses), 32'd1);
    check("single_log", 32'(log_q[0]), 32'hA5);

    // Burst 0x01..0x10 back to back.
    tick(2);
    log_q.delete();
    dv_pulses = 0;
    accepted  = 0;
    peak      = 0;
    for (int i = 1; i <= 16; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i);
      if (wr_ready) accepted++;
      tick(1);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (i == 2) check("push_pop_same_cycle", 32'(fifo_count), 32'd1);
    end
    wr_valid = 1'b0;
    check("burst_accepted", 32'(accepted), 32'd16);
    check("burst_peak", 32'(peak >= 15), 32'd1);
    wait_idle("burst_idle", 1500);
    check("burst_pulses", 32'(dv_pulses), 32'd16);
    check("burst_log_size", 32'(log_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("burst_byte%0d", i), 32'(log_q[i]), 32'(i + 1));
    end

    // Full FIFO with the transmitter stalled on an in-flight byte.
    tick(2);
    stall    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    tick(1);
    wr_valid = 1'b0;
    tick(3);
    log_q.delete();
    dv_pulses = 0;
    accepted  = 0;
    for (int i = 0; i < 17; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(8'h20 + i);
      if (wr_ready) accepted++;
      tick(1);
    end
    wr_valid = 1'b0;
    check("full_accepted", 32'(accepted), 32'd16);
    check("full_count", 32'(fifo_count), 32'd16);
    check("full_wr_ready", 32'(wr_ready), 32'd0);
    check("full_overflow", 32'(overflow), 32'd1);
    check("full_no_dv", 32'(dv_pulses), 32'd0);
    wr_valid     = 1'b1;
    clr_overflow = 1'b1;
    tick(1);
    wr_valid = 1'b0;
    check("clr_vs_reject", 32'(overflow), 32'd1);
    tick(1);
    clr_overflow = 1'b0;
    check("clr_alone", 32'(overflow), 32'd0);
    check("full_count_held", 32'(fifo_count), 32'd16);
    stall = 1'b0;
    wait_idle("full_idle", 1500);
    check("full_log_size", 32'(log_q.size()), 32'd16);
    order_err = 0;
    for (int i = 0; i < 16; i++) begin
      if (log_q[i] !== 8'(8'h20 + i)) order_err++;
    end
    check("full_order", 32'(order_err), 32'd0);

    // Reset while waiting on tx_done with 5 bytes queued.
    tick(2);
    stall     = 1'b1;
    dv_pulses = 0;
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(8'h40 + i);
      tick(1);
    end
    wr_valid = 1'b0;
    tick(4);
    check("mid_count", 32'(fifo_count), 32'd5);
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_pulses", 32'(dv_pulses), 32'd1);
    reset = 1'b1;
    tick(2);
    reset     = 1'b0;
    stall     = 1'b0;
    dv_pulses = 0;
    log_q.delete();
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_wr_ready", 32'(wr_ready), 32'd1);
    tick(20);
    check("mid_rst_no_dv", 32'(dv_pulses), 32'd0);
    wr_valid = 1'b1;
    wr_data  = 8'h5A;
    tick(1);
    wr_valid = 1'b0;
    wait_idle("mid_new_idle", 200);
    check("mid_new_pulses", 32'(dv_pulses), 32'd1);
    check("mid_new_byte", 32'(log_q[0]), 32'h5A);

    check("dv_double", 32'(dv_double), 32'd0);
    check("dv_during_done", 32'(dv_during_done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
